// File: rtl/tug_pkg.sv
// Shared constants and helpers for the tug-of-war scorer.
package tug_pkg;
  localparam int LED_W = 9;

  localparam logic [3:0] POS_MIN    = 4'd0;
  localparam logic [3:0] POS_CENTRE = 4'd4;
  localparam logic [3:0] POS_MAX    = 4'd8;
  localparam logic [3:0] SCORE_MAX  = 4'd9;

  localparam logic [1:0] LED_ALL = 2'b11;
  localparam logic [1:0] LED_POS = 2'b10;
  localparam logic [1:0] LED_OFF = 2'b00;

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction
endpackage

// File: rtl/tug_scorer_led_decode.sv
// Combinational LED pattern: all-on, one-hot rope position, or dark.
module led_decode
  import tug_pkg::*;
(
  input  logic [3:0]       pos,
  input  logic             leds_on,
  input  logic [1:0]       led_control,
  output logic [LED_W-1:0] pattern
);
  generate
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
      assign pattern[gi] = leds_on &&
                           ((led_control == LED_ALL) ||
                            ((led_control == LED_POS) && (pos == 4'(gi))));
    end
  endgenerate
endmodule

// File: rtl/tug_scorer.sv
// Tug-of-war rope position, round win detection and per-player scores.
module tug_scorer
  import tug_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pbl,
  input  logic             pbr,
  input  logic             clear,
  input  logic             leds_on,
  input  logic [1:0]       led_control,
  output logic             winrnd,
  output logic [LED_W-1:0] leds,
  output logic [3:0]       score_l,
  output logic [3:0]       score_r
);
  logic [3:0]       pos_reg, pos_next;
  logic             win_reg, win_next;
  logic             clear_d_reg;
  logic [3:0]       score_l_reg, score_l_next;
  logic [3:0]       score_r_reg, score_r_next;
  logic [LED_W-1:0] leds_reg, pattern;
  logic             move_left;

  led_decode u_led_decode (
    .pos         (pos_reg),
    .leds_on     (leds_on),
    .led_control (led_control),
    .pattern     (pattern)
  );

  // In the dark phase an early press pulls the rope toward the opponent.
  assign move_left = leds_on ? pbl : pbr;

  always_comb begin
    pos_next     = pos_reg;
    win_next     = win_reg;
    score_l_next = score_l_reg;
    score_r_next = score_r_reg;
    if (led_control[0]) begin
      pos_next     = POS_CENTRE;
      win_next     = 1'b0;
      score_l_next = '0;
      score_r_next = '0;
    end else if (clear) begin
      win_next = 1'b0;
    end else if (clear_d_reg) begin
      pos_next = POS_CENTRE;
    end else if (!win_reg && (pbl ^ pbr)) begin
      if (move_left) begin
        if (pos_reg != POS_MIN) pos_next = pos_reg - 4'd1;
      end else begin
        if (pos_reg != POS_MAX) pos_next = pos_reg + 4'd1;
      end
      if (pos_next == POS_MIN) begin
        win_next     = 1'b1;
        score_l_next = score_inc(score_l_reg);
      end else if (pos_next == POS_MAX) begin
        win_next     = 1'b1;
        score_r_next = score_inc(score_r_reg);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_reg     <= POS_CENTRE;
      win_reg     <= 1'b0;
      clear_d_reg <= 1'b1;
      score_l_reg <= '0;
      score_r_reg <= '0;
      leds_reg    <= '0;
    end else begin
      pos_reg     <= pos_next;
      win_reg     <= win_next;
      clear_d_reg <= clear;
      score_l_reg <= score_l_next;
      score_r_reg <= score_r_next;
      leds_reg    <= pattern;
    end
  end

  assign winrnd  = win_reg;
  assign leds    = leds_reg;
  assign score_l = score_l_reg;
  assign score_r = score_r_reg;
endmodule
